wait_state_dmem: RTL and testbench

- Word-addressed data memory acting as the responder on the processor data-memory interface.
- Adds a request/ready handshake and a fixed, parameterised access latency.
- Lets the multi-cycle and pipelined cores be tested against realistic memory stalls.
- Sits in the top level next to the instruction memory.
- Driven by the core's address, write-data and write-enable outputs plus a request strobe.

---
 rtl/wait_state_dmem.sv | 148 ++++++++++++++
 tb/tb_wait_state_dmem.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_dmem.sv
// Purpose : word-addressed data memory with req/ready handshake and fixed LAT-cycle access latency.
// Latency : Ready is asserted LAT-1 cycles after the accept edge (seen by the core at edge E0+LAT).
// Backpr. : one access in flight; Req while Busy=1 is ignored (not queued), re-assert after Ready.
//
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   Req        access request, sampled only while Busy=0
//   MemWrite   1 = write, 0 = read (sampled with Req)
//   DataAdr    byte address; DataAdr[AW+1:2] selects the word, upper bits wrap
//   WriteData  store data (sampled with Req)
//   ReadData   registered read data, nonzero only while Ready=1 on a read
//   Ready      one-cycle completion pulse
//   Busy       high while a transaction is in flight (state != IDLE)
//   AlignErr   (only with DMEM_ALIGN_CHECK_EN) misaligned-access flag, alongside Ready
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
module wait_state_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        AlignErr
`endif
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_bad_lat
            $error("wait_state_dmem: LAT must be in 1..15");
        end
        if (DEPTH != (1 << AW)) begin : g_bad_depth
            $error("wait_state_dmem: DEPTH must equal 2**AW");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wd_q;
    logic            we_q;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            commit;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wd;
    logic            acc_we;
    logic            acc_bad;   // access is misaligned and must not touch the array

    // Address bits above the word index are deliberately ignored (wrap).
    logic            unused_adr_hi;
    assign unused_adr_hi = ^DataAdr[31:AW+2];

    assign accept = (state_q == IDLE) && Req;

    // The commit edge is the edge entering RESP. With LAT=1 that is the
    // accept edge itself, so the access must use the live inputs there.
    assign commit = (accept && (LAT == 1)) || ((state_q == WAIT) && (cnt_q == 4'd1));

    assign acc_idx = (state_q == IDLE) ? DataAdr[AW+1:2] : idx_q;
    assign acc_wd  = (state_q == IDLE) ? WriteData       : wd_q;
    assign acc_we  = (state_q == IDLE) ? MemWrite        : we_q;

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0]      lo_q;
    logic [1:0]      acc_lo;
    assign acc_lo  = (state_q == IDLE) ? DataAdr[1:0] : lo_q;
    assign acc_bad = (acc_lo != 2'b00);
`else
    logic            unused_adr_lo;
    assign unused_adr_lo = ^DataAdr[1:0];
    assign acc_bad = 1'b0;
`endif

    assign Busy  = (state_q != IDLE);
    assign Ready = (state_q == RESP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Req) state_d = (LAT == 1) ? RESP : WAIT;
            WAIT: if (cnt_q == 4'd1) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            wd_q     <= 32'd0;
            we_q     <= 1'b0;
            ReadData <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= CNT_LOAD;
                idx_q <= DataAdr[AW+1:2];
                wd_q  <= WriteData;
                we_q  <= MemWrite;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // ReadData carries data only for the RESP cycle of a good read.
            if (commit && !acc_we && !acc_bad) ReadData <= mem[acc_idx];
            else                               ReadData <= 32'd0;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            lo_q     <= 2'b00;
            AlignErr <= 1'b0;
        end else begin
            if (accept) lo_q <= DataAdr[1:0];
            AlignErr <= commit && acc_bad;
        end
    end
`endif

    // Array is not reset; the Reset gate keeps a dropped transaction from writing.
    always_ff @(posedge clk) begin
        if (Reset && commit && acc_we && !acc_bad) mem[acc_idx] <= acc_wd;
    end

endmodule

// File: tb/tb_wait_state_dmem.sv
module tb_wait_state_dmem;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Busy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        AlignErr;
`endif

    wait_state_dmem #(.DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Req       (Req),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .Busy      (Busy)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .AlignErr  (AlignErr)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference memory: the array as the initiator sees it.
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_ae;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic aligned(input logic [31:0] adr);
`ifdef DMEM_ALIGN_CHECK_EN
        return adr[1:0] == 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] adr);
        return int'(adr[AW+1:2]);
    endfunction

    // One complete transaction. After the accept edge the inputs are
    // scrambled and Req is held high to show nothing in flight is disturbed
    // and nothing is accepted while busy.
    task automatic access(input string nm, input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ae);
        int k;
        chk({nm, " idle before"}, {31'd0, Busy}, 32'd0);
        Req = 1'b1; MemWrite = we; DataAdr = adr; WriteData = wd;
        tick();                                  // accept edge E0
        k = 0;
        Req = 1'b1; MemWrite = 1'($urandom); DataAdr = $urandom; WriteData = $urandom;
        while (!Ready && k < 20) begin
            tick();
            k++;
            MemWrite = 1'($urandom); DataAdr = $urandom; WriteData = $urandom;
        end
        chk({nm, " latency"}, 32'(k), 32'(LAT - 1));
        chk({nm, " data"}, ReadData, exp_rd);
        chk({nm, " busy at ready"}, {31'd0, Busy}, 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
        chk({nm, " alignerr"}, {31'd0, AlignErr}, {31'd0, exp_ae});
`else
        if (exp_ae) $display("note: %s misaligned, containing word expected", nm);
`endif
        tick();                                  // RESP -> IDLE, Req still high
        Req = 1'b0;
        chk({nm, " ready drop"}, {31'd0, Ready}, 32'd0);
        chk({nm, " rdata drop"}, ReadData, 32'd0);
        tick();                                  // Req during busy must not have queued
        chk({nm, " not queued"}, {31'd0, Busy}, 32'd0);
    endtask

    // Access whose expectation comes from the reference model.
    task automatic model_access(input string nm, input logic we, input logic [31:0] adr,
                                input logic [31:0] wd);
        logic [31:0] exp;
        exp = (!we && aligned(adr)) ? ref_mem[widx(adr)] : 32'd0;
        access(nm, we, adr, wd, exp, !aligned(adr));
        if (we && aligned(adr)) ref_mem[widx(adr)] = wd;
    endtask

    initial begin
        int nacc, nrdy, last_e;
        logic [31:0] a;

        tbl[0] = '{1'b1, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h00, 32'h11,       32'h0,        1'b0};
        tbl[3] = '{1'b1, 32'h04, 32'h22,       32'h0,        1'b0};
        tbl[4] = '{1'b1, 32'h0C, 32'hA5A5A5A5, 32'h0,        1'b0};
        tbl[5] = '{1'b1, 32'h08, 32'h5,        32'h0,        1'b0};
        tbl[6] = '{1'b0, 32'h08, 32'h0,        32'h5,        1'b0};
        tbl[7] = '{1'b0, 32'h0C, 32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[8] = '{1'b1, 32'h10, 32'h0000600D, 32'h0,        1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[9] = '{1'b0, 32'h23, 32'h0,        32'h0,        1'b1};
`else
        tbl[9] = '{1'b0, 32'h23, 32'h0,        32'hDEADBEEF, 1'b1};
`endif

        // Reset hold then release with Req idle.
        Reset = 1'b0; Req = 1'b0; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
        tick(); tick();
        chk("in reset ready", {31'd0, Ready}, 32'd0);
        chk("in reset busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle ready", {31'd0, Ready}, 32'd0);
            chk("idle busy", {31'd0, Busy}, 32'd0);
            chk("idle rdata", ReadData, 32'd0);
        end

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            access($sformatf("tbl%0d", i), tbl[i].we, tbl[i].adr, tbl[i].wd,
                   tbl[i].exp_rd, tbl[i].exp_ae);
            if (tbl[i].we && aligned(tbl[i].adr)) ref_mem[widx(tbl[i].adr)] = tbl[i].wd;
        end

        // Req held high, alternating 0x0/0x4: one access per LAT+1 cycles.
        nacc = 0; nrdy = 0; last_e = -1;
        Req = 1'b1; MemWrite = 1'b0;
        for (int e = 0; e < 3 * (LAT + 1); e++) begin
            if (!Busy) begin
                DataAdr = nacc[0] ? 32'h4 : 32'h0;
                nacc++;
            end
            tick();
            if (Ready) begin
                chk($sformatf("stream data %0d", nrdy), ReadData, nrdy[0] ? 32'h22 : 32'h11);
                if (nrdy > 0) chk("stream period", 32'(e - last_e), 32'(LAT + 1));
                last_e = e;
                nrdy++;
            end
        end
        Req = 1'b0;
        chk("stream count", 32'(nrdy), 32'd3);
        tick();
        chk("stream idle", {31'd0, Busy}, 32'd0);

        // Address wrap: 4*DEPTH aliases word 0.
        model_access("wrap wr", 1'b1, 32'h100, 32'hCAFE0001);
        access("wrap rd", 1'b0, 32'h0, 32'h0, 32'hCAFE0001, 1'b0);

        // Reset while in WAIT drops the write and any Ready.
        Req = 1'b1; MemWrite = 1'b1; DataAdr = 32'h10; WriteData = 32'h1234;
        tick();
        Req = 1'b0;
        chk("pre-reset busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b0;
        #2;
        chk("async reset busy", {31'd0, Busy}, 32'd0);
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post-reset no ready", {31'd0, Ready}, 32'd0);
        end
        access("dropped wr", 1'b0, 32'h10, 32'h0, 32'h0000600D, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        access("misaligned wr", 1'b1, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
        access("aligned rd", 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0);
`endif

        // Fill every word so the model knows the whole array, then randomize.
        for (int i = 0; i < DEPTH; i++) model_access("fill", 1'b1, 32'(i * 4), $urandom);
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            model_access($sformatf("rand%0d", i), 1'($urandom), a, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
